// File: rtl/math_addsub_multiword_seq.sv
// Multi-limb add/subtract sequencer: one N-bit adder reused per limb, LS limb first,
// with the carry/borrow chained between limbs in a register.
//
// state | meaning
// IDLE  | waiting for a command; o_cmd_ready high
// RUN   | accepting operand limbs, one result limb per accepted limb
// FLUSH | last result limb issued, waiting for the consumer to take it
module math_addsub_multiword_seq #(
    parameter int N         = 32,
    parameter int MAX_LIMBS = 8,
    parameter int LW        = $clog2(MAX_LIMBS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_sub,
    input  logic [LW-1:0] i_cmd_limbs,
    input  logic          i_limb_valid,
    output logic          o_limb_ready,
    input  logic [N-1:0]  i_limb_a,
    input  logic [N-1:0]  i_limb_b,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [N-1:0]  o_res_sum,
    output logic          o_res_last,
    output logic          o_res_carry,
    output logic          o_res_ovf,
    output logic          o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    logic          sub_q;
    logic          carry_q;
    logic [LW-1:0] remaining;

    logic [N-1:0]  b_x;
    logic [N:0]    full;
    logic          c_msb;
    logic          is_last;
    logic          limb_fire;
    logic          res_fire;
    logic [LW-1:0] limbs_clamped;

    assign o_cmd_ready  = (state == IDLE);
    assign o_busy       = (state != IDLE);
    assign o_limb_ready = (state == RUN) && (!o_res_valid || i_res_ready);
    assign limb_fire    = i_limb_valid && o_limb_ready;
    assign res_fire     = o_res_valid && i_res_ready;

    // Subtraction is A + ~B + 1, the +1 coming from the carry register seeded at command time.
    assign b_x     = i_limb_b ^ {N{sub_q}};
    assign full    = {1'b0, i_limb_a} + {1'b0, b_x} + {{N{1'b0}}, carry_q};
    assign c_msb   = full[N-1] ^ i_limb_a[N-1] ^ b_x[N-1];
    assign is_last = (remaining == LW'(1));

    always_comb begin
        limbs_clamped = i_cmd_limbs;
        if (i_cmd_limbs == '0)
            limbs_clamped = LW'(1);
        else if (i_cmd_limbs > LW'(MAX_LIMBS))
            limbs_clamped = LW'(MAX_LIMBS);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            remaining   <= '0;
            o_res_valid <= 1'b0;
            o_res_sum   <= '0;
            o_res_last  <= 1'b0;
            o_res_carry <= 1'b0;
            o_res_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (res_fire)
                        o_res_valid <= 1'b0;
                    if (i_cmd_valid) begin
                        sub_q     <= i_cmd_sub;
                        carry_q   <= i_cmd_sub;
                        remaining <= limbs_clamped;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (limb_fire) begin
                        carry_q     <= full[N];
                        remaining   <= remaining - LW'(1);
                        o_res_valid <= 1'b1;
                        o_res_sum   <= full[N-1:0];
                        o_res_last  <= is_last;
                        o_res_carry <= is_last ? full[N] : 1'b0;
                        o_res_ovf   <= is_last ? (c_msb ^ full[N]) : 1'b0;
                        if (is_last)
                            state <= FLUSH;
                    end else if (res_fire) begin
                        o_res_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (res_fire) begin
                        o_res_valid <= 1'b0;
                        if (o_res_last)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_math_addsub_multiword_seq.sv
// Bench for math_addsub_multiword_seq (N=8, MAX_LIMBS=8): vector table driven through
// a scoreboard queue, plus hand sequences for backpressure, clamping and mid-op reset.
module tb_math_addsub_multiword_seq;

    localparam int N  = 8;
    localparam int ML = 8;
    localparam int LW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_sub;
    logic [LW-1:0] i_cmd_limbs;
    logic          i_limb_valid;
    logic          o_limb_ready;
    logic [N-1:0]  i_limb_a;
    logic [N-1:0]  i_limb_b;
    logic          o_res_valid;
    logic          i_res_ready;
    logic [N-1:0]  o_res_sum;
    logic          o_res_last;
    logic          o_res_carry;
    logic          o_res_ovf;
    logic          o_busy;

    math_addsub_multiword_seq #(.N(N), .MAX_LIMBS(ML)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_sub(i_cmd_sub), .i_cmd_limbs(i_cmd_limbs),
        .i_limb_valid(i_limb_valid), .o_limb_ready(o_limb_ready),
        .i_limb_a(i_limb_a), .i_limb_b(i_limb_b),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_sum(o_res_sum), .o_res_last(o_res_last),
        .o_res_carry(o_res_carry), .o_res_ovf(o_res_ovf), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        sub;
        logic [3:0]  limbs;
        int          supply;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        carry;
        logic        ovf;
        int          cnt;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       last;
        logic       carry;
        logic       ovf;
    } exp_t;

    vec_t vt[10];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] limb_of(input logic [63:0] x, input int i);
        logic [63:0] s;
        if (i >= 8) return 8'hA5;
        s = x >> (8 * i);
        return s[7:0];
    endfunction

    task automatic run_vec(input int v, input int stall_start, input int stall_len);
        int   cyc = 0, li = 0, got = 0;
        bit   cmd_done = 0, held = 0, lat_pend = 0;
        logic [7:0] h_sum;
        logic h_last;
        exp_t e;
        while (got < vt[v].cnt && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
            // command stays asserted (with different fields) after acceptance to prove it is ignored
            i_cmd_valid  = 1'b1;
            i_cmd_sub    = cmd_done ? ~vt[v].sub : vt[v].sub;
            i_cmd_limbs  = cmd_done ? 4'd1 : vt[v].limbs;
            i_limb_valid = cmd_done && (li < vt[v].supply);
            i_limb_a     = limb_of(vt[v].a, li);
            i_limb_b     = limb_of(vt[v].b, li);
            i_res_ready  = !(cyc >= stall_start && cyc < stall_start + stall_len);
            #1;
            if (lat_pend) chk("latency_valid", o_res_valid, 1);
            if (held) begin
                chk("hold_valid", o_res_valid, 1);
                chk("hold_sum", o_res_sum, h_sum);
                chk("hold_last", o_res_last, h_last);
                chk("stall_limb_ready", o_limb_ready, i_res_ready);
            end
            if (cmd_done) chk("cmd_ready_busy", o_cmd_ready, 0);
            else if (o_cmd_ready) cmd_done = 1;
            lat_pend = 0;
            if (i_limb_valid && o_limb_ready) begin
                if (li >= vt[v].cnt) begin
                    chk("extra_limb_accepted", li, vt[v].cnt - 1);
                end else begin
                    e.sum   = limb_of(vt[v].res, li);
                    e.last  = (li == vt[v].cnt - 1);
                    e.carry = e.last ? vt[v].carry : 1'b0;
                    e.ovf   = e.last ? vt[v].ovf : 1'b0;
                    sb.push_back(e);
                end
                li++;
                lat_pend = 1;
            end
            if (o_res_valid && i_res_ready) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d_sum%0d", v, got), o_res_sum, e.sum);
                    chk($sformatf("v%0d_last%0d", v, got), o_res_last, e.last);
                    chk($sformatf("v%0d_carry%0d", v, got), o_res_carry, e.carry);
                    chk($sformatf("v%0d_ovf%0d", v, got), o_res_ovf, e.ovf);
                end
                got++;
            end
            held   = o_res_valid && !i_res_ready;
            h_sum  = o_res_sum;
            h_last = o_res_last;
        end
        chk($sformatf("v%0d_result_count", v), got, vt[v].cnt);
        @(negedge i_clk);
        i_cmd_valid  = 1'b0;
        i_limb_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_limbs_accepted", v), li, vt[v].cnt);
        chk($sformatf("v%0d_cmd_ready_after", v), o_cmd_ready, 1);
        chk($sformatf("v%0d_busy_after", v), o_busy, 0);
        chk($sformatf("v%0d_valid_after", v), o_res_valid, 0);
        chk($sformatf("v%0d_sb_empty", v), sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          sub  limbs sup  a                        b                        res                      c     o     cnt
        vt[0] = '{1'b0, 4'd1,  1,  64'hFF,                  64'h01,                  64'h00,                  1'b1, 1'b0, 1};
        vt[1] = '{1'b1, 4'd2,  2,  64'h0100,                64'h0001,                64'h00FF,                1'b1, 1'b0, 2};
        vt[2] = '{1'b0, 4'd1,  1,  64'h7F,                  64'h01,                  64'h80,                  1'b0, 1'b1, 1};
        vt[3] = '{1'b1, 4'd1,  1,  64'h80,                  64'h01,                  64'h7F,                  1'b1, 1'b1, 1};
        vt[4] = '{1'b0, 4'd4,  4,  64'h12FF34FF,            64'h00010201,            64'h13003700,            1'b0, 1'b0, 4};
        vt[5] = '{1'b1, 4'd0,  1,  64'h05,                  64'h03,                  64'h02,                  1'b1, 1'b0, 1};
        vt[6] = '{1'b0, 4'd12, 12, 64'hFFFFFFFFFFFFFFFF,    64'h01,                  64'h0,                   1'b1, 1'b0, 8};
        vt[7] = '{1'b1, 4'd3,  3,  64'h000000,              64'h000001,              64'hFFFFFF,              1'b0, 1'b0, 3};
        vt[8] = '{1'b0, 4'd2,  2,  64'h7FFF,                64'h0001,                64'h8000,                1'b0, 1'b1, 2};
        vt[9] = '{1'b0, 4'd1,  1,  64'h01,                  64'h01,                  64'h02,                  1'b0, 1'b0, 1};

        i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_sub = 1'b0; i_cmd_limbs = '0;
        i_limb_valid = 1'b0; i_limb_a = '0; i_limb_b = '0; i_res_ready = 1'b1;
        #13;
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_res_sum", o_res_sum, 0);
        chk("rst_res_last", o_res_last, 0);
        chk("rst_res_carry", o_res_carry, 0);
        chk("rst_res_ovf", o_res_ovf, 0);
        chk("rst_busy", o_busy, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_limb_ready", o_limb_ready, 0);

        for (int v = 0; v < 9; v++)
            run_vec(v, (v == 4) ? 4 : -1, 3);

        // Abort a 4-limb add after two limbs, with carry_reg=1 left behind.
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_sub = 1'b0; i_cmd_limbs = 4'd4; i_res_ready = 1'b1;
        @(negedge i_clk);
        i_cmd_valid = 1'b0; i_limb_valid = 1'b1; i_limb_a = 8'hFF; i_limb_b = 8'h01;
        #1 chk("abort_limb0_ready", o_limb_ready, 1);
        @(negedge i_clk);
        i_limb_a = 8'hFF; i_limb_b = 8'h00;
        #1 chk("abort_limb1_ready", o_limb_ready, 1);
        @(negedge i_clk);
        i_limb_valid = 1'b0;
        #1;
        chk("abort_pre_valid", o_res_valid, 1);
        chk("abort_pre_busy", o_busy, 1);
        #1 i_rst_n = 1'b0;
        #1;
        chk("abort_res_valid", o_res_valid, 0);
        chk("abort_res_sum", o_res_sum, 0);
        chk("abort_res_carry", o_res_carry, 0);
        chk("abort_busy", o_busy, 0);
        sb.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 chk("abort_cmd_ready", o_cmd_ready, 1);
        run_vec(9, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/math_addsub_multiword_seq.md
Name: math_addsub_multiword_seq

Overview:
- Sequences one N-bit ripple add/sub datapath across multi-limb operands, least-significant limb first.
- Carry/borrow is chained between limbs in a register, so wide add/sub (e.g. 256-bit) reuses a narrow adder at one limb per cycle.
- Sits between a command/operand producer and a result consumer.
- Valid/ready handshakes on command, limb-input and result channels.

Parameters:
- N, 32, limb width in bits
- MAX_LIMBS, 8, maximum limbs per command
- LW, $clog2(MAX_LIMBS+1), width of the limb-count field

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_cmd_valid  input  1  command valid
- o_cmd_ready  output  1  command accepted when valid&ready
- i_cmd_sub  input  1  0 = add, 1 = subtract (A-B)
- i_cmd_limbs  input  LW  limb count for the command
- i_limb_valid  input  1  operand limb valid
- o_limb_ready  output  1  limb accepted when valid&ready
- i_limb_a  input  N  operand A limb
- i_limb_b  input  N  operand B limb
- o_res_valid  output  1  result limb valid
- i_res_ready  input  1  consumer ready
- o_res_sum  output  N  result limb
- o_res_last  output  1  marks the final limb of the command
- o_res_carry  output  1  final carry-out, valid with last; for sub, 1 = no borrow (A>=B unsigned)
- o_res_ovf  output  1  signed overflow of the full-width result, valid with last
- o_busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE.
  - o_res_valid, o_res_sum, o_res_last, o_res_carry, o_res_ovf, o_busy all 0.
  - Carry register, sub register and limb counter cleared.
- States: IDLE, RUN, FLUSH.
- o_cmd_ready = (state==IDLE). It is 1 immediately after reset deasserts.
- IDLE -> RUN on command handshake.
  - Latch sub.
  - Carry register <= i_cmd_sub.
  - Remaining <= clamp(i_cmd_limbs): 0 becomes 1; values >MAX_LIMBS become MAX_LIMBS.
- o_limb_ready = (state==RUN) && (!o_res_valid || i_res_ready). No combinational path from i_limb_valid to o_limb_ready.
- On limb handshake:
  - {cout, sum} = a + (b XOR {N{sub}}) + carry_reg, computed at width N+1.
  - carry_reg <= cout.
  - o_res_sum <= sum; o_res_valid <= 1.
  - o_res_last <= (remaining==1); remaining decrements.
- On the last limb:
  - o_res_carry <= cout.
  - o_res_ovf <= carry into bit N-1 XOR cout.
  - State -> FLUSH.
- On non-last limbs, o_res_carry and o_res_ovf are 0.
- Latency: result limb valid exactly 1 cycle after its limb handshake.
- Throughput: 1 limb/cycle while i_res_ready=1.
- Output register:
  - o_res_* hold stable while o_res_valid && !i_res_ready.
  - o_res_valid clears on result handshake unless a new limb is accepted in the same cycle. Simultaneous handshake + accept replaces the register; there are no bubbles.
- FLUSH -> IDLE on result handshake with o_res_last=1. o_cmd_ready rises the following cycle.
- i_limb_valid is ignored outside RUN. i_cmd_valid is ignored outside IDLE.
- Reset mid-operation:
  - Asynchronous return to IDLE; in-flight result discarded; all outputs return to reset values.
  - No state from the aborted command affects the next command.

Test Plan (N=8, MAX_LIMBS=8):
- Single-limb add: limbs=1, sub=0, a=0xFF, b=0x01 -> next cycle o_res_sum=0x00, last=1, carry=1, ovf=0; o_cmd_ready=1 cycle after handshake.
- Two-limb subtract 0x0100-0x0001: limbs (a,b)=(0x00,0x01),(0x01,0x00) -> results 0xFF (last=0), then 0x00 (last=1, carry=1, ovf=0); back-to-back cycles with i_res_ready=1.
- Signed overflow: limbs=1, sub=0, 0x7F+0x01 -> sum=0x80, ovf=1, carry=0. Also sub 0x80-0x01 -> sum=0x7F, ovf=1, carry=1.
- Backpressure: 4-limb add, i_res_ready low 3 cycles mid-stream -> o_limb_ready low, o_res_sum/last stable, 4 results in order, no limb lost or duplicated, carry chain correct.
- Clamp: limbs=0 -> exactly 1 result with last=1. limbs=12 -> exactly 8 results, last on the 8th, extra limbs not accepted.
- Async reset after 2 of 4 limbs -> outputs 0 within the reset cycle, o_cmd_ready=1 after release. Next 1-limb add 0x01+0x01 yields 0x02, carry=0 (no stale carry).
